// File: rtl/l1_miss_tracker.sv
// l1_miss_tracker: tracks outstanding L1 line misses with merge, read-to-write promotion,
// round-robin request arbitration, fills with thread wakeups and registered snoop lookups.
module l1_miss_tracker #(
    parameter int NUM_ENTRIES = 4,
    parameter int NUM_WAITERS = 4,
    parameter int ADDR_WIDTH = 26,
    localparam int EW = $clog2(NUM_ENTRIES),
    localparam int WW = NUM_WAITERS > 1 ? $clog2(NUM_WAITERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  miss_store,
    input  logic [WW-1:0]         miss_waiter_idx,
    input  logic                  snoop_en,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  snoop_hit,
    output logic [EW-1:0]         snoop_entry,
    output logic [1:0]            snoop_state,
    input  logic                  fill_en,
    input  logic [EW-1:0]         fill_entry,
    output logic [NUM_WAITERS-1:0] wake_oh,
    output logic                  request_valid,
    output logic [ADDR_WIDTH-1:0] request_addr,
    output logic                  request_store,
    output logic [EW-1:0]         request_entry,
    input  logic                  request_ack,
    output logic [EW:0]           occupancy
);
    typedef enum logic [1:0] {READ_PENDING, READ_SENT, WRITE_PENDING, WRITE_SENT} state_t;
    logic                   r_valid [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  r_addr [NUM_ENTRIES];
    state_t                 r_state [NUM_ENTRIES];
    logic [NUM_WAITERS-1:0] r_waiters [NUM_ENTRIES];
    logic [NUM_WAITERS-1:0] r_store_waiters [NUM_ENTRIES];
    logic                   r_upgrade [NUM_ENTRIES];
    logic [EW-1:0]          r_rr;
    logic [NUM_WAITERS-1:0] r_wake;
    logic [EW:0]            r_occ;
    logic                   r_snoop_hit;
    logic [EW-1:0]          r_snoop_entry;
    logic [1:0]             r_snoop_state;
    logic [NUM_ENTRIES-1:0] w_hit;
    logic [NUM_ENTRIES-1:0] w_pend;
    logic [NUM_WAITERS-1:0] w_onehot;
    logic [NUM_WAITERS-1:0] w_waiting;
    logic [EW-1:0]          w_free_idx;
    logic [EW-1:0]          w_gnt;
    logic w_collide, w_any_free, w_found, w_accept, w_alloc, w_ack, w_fill_free;
    // The entry under fill is excluded from the compare so a new miss to its line allocates afresh.
    always_comb begin
        w_hit = '0;
        w_pend = '0;
        w_waiting = '0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_found = 1'b0;
        w_gnt = '0;
        w_onehot = NUM_WAITERS'(1) << miss_waiter_idx;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            w_hit[i] = r_valid[i] && r_addr[i] == miss_addr && !(fill_en && fill_entry == EW'(i));
            w_pend[i] = r_valid[i] && (r_state[i] == READ_PENDING || r_state[i] == WRITE_PENDING);
            w_waiting = w_waiting | (r_valid[i] ? r_waiters[i] & w_onehot : '0);
            w_any_free = w_any_free || !r_valid[i];
            w_free_idx = !r_valid[i] ? EW'(i) : w_free_idx;
        end
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            if (w_pend[(int'(r_rr) + k) % NUM_ENTRIES]) begin
                w_found = 1'b1;
                w_gnt = EW'((int'(r_rr) + k) % NUM_ENTRIES);
            end
        end
        w_collide = |w_hit;
    end
    assign miss_ready = w_collide || w_any_free;
    assign w_accept = miss_valid && miss_ready;
    assign w_alloc = w_accept && !w_collide;
    assign w_ack = request_ack && w_found;
    assign w_fill_free = fill_en && !r_upgrade[fill_entry];
    assign request_valid = w_found;
    assign request_addr = w_found ? r_addr[w_gnt] : '0;
    assign request_store = w_found && r_state[w_gnt] == WRITE_PENDING;
    assign request_entry = w_found ? w_gnt : '0;
    assign wake_oh = r_wake;
    assign occupancy = r_occ;
    assign snoop_hit = r_snoop_hit;
    assign snoop_entry = r_snoop_entry;
    assign snoop_state = r_snoop_state;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i] <= '0;
                r_state[i] <= READ_PENDING;
                r_waiters[i] <= '0;
                r_store_waiters[i] <= '0;
                r_upgrade[i] <= 1'b0;
            end
            r_rr <= '0;
            r_wake <= '0;
            r_occ <= '0;
            r_snoop_hit <= 1'b0;
            r_snoop_entry <= '0;
            r_snoop_state <= '0;
        end else begin
            r_wake <= !fill_en ? '0 : r_upgrade[fill_entry] ? r_waiters[fill_entry] & ~r_store_waiters[fill_entry] : r_waiters[fill_entry];
            r_occ <= r_occ + (EW + 1)'(w_alloc) - (EW + 1)'(w_fill_free);
            if (w_ack) r_rr <= EW'((int'(w_gnt) + 1) % NUM_ENTRIES);
            r_snoop_hit <= 1'b0;
            r_snoop_entry <= '0;
            r_snoop_state <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (snoop_en && r_valid[i] && r_addr[i] == snoop_addr) begin
                    r_snoop_hit <= 1'b1;
                    r_snoop_entry <= EW'(i);
                    r_snoop_state <= r_state[i];
                end
                if (fill_en && fill_entry == EW'(i)) begin
                    if (r_upgrade[i]) begin
                        r_state[i] <= WRITE_PENDING;
                        r_waiters[i] <= r_store_waiters[i];
                        r_upgrade[i] <= 1'b0;
                    end else r_valid[i] <= 1'b0;
                end else if (w_alloc && w_free_idx == EW'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i] <= miss_addr;
                    r_state[i] <= miss_store ? WRITE_PENDING : READ_PENDING;
                    r_waiters[i] <= w_onehot;
                    r_store_waiters[i] <= miss_store ? w_onehot : '0;
                    r_upgrade[i] <= 1'b0;
                end else begin
                    if (w_ack && w_gnt == EW'(i)) r_state[i] <= r_state[i] == READ_PENDING ? READ_SENT : WRITE_SENT;
                    if (w_accept && w_hit[i]) begin
                        r_waiters[i] <= r_waiters[i] | w_onehot;
                        if (miss_store) r_store_waiters[i] <= r_store_waiters[i] | w_onehot;
                        // A store arriving after (or with) the read going out needs a second, write request.
                        if (miss_store && !(w_ack && w_gnt == EW'(i)) && r_state[i] == READ_PENDING) r_state[i] <= WRITE_PENDING;
                        if (miss_store && ((w_ack && w_gnt == EW'(i)) || r_state[i] == READ_SENT)) r_upgrade[i] <= 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(w_hit));
            assert (!(w_accept && |w_waiting));
            assert (!fill_en || (r_valid[fill_entry] && (r_state[fill_entry] == READ_SENT || r_state[fill_entry] == WRITE_SENT)));
        end
    end
endmodule

// File: tb/tb_l1_miss_tracker.sv
// tb_l1_miss_tracker: directed scenarios plus randomized traffic checked against a
// behavioural model of the miss table.
module tb_l1_miss_tracker;
    logic clk = 1'b0;
    logic reset, miss_valid, miss_ready, miss_store, snoop_en, snoop_hit, fill_en;
    logic request_valid, request_store, request_ack;
    logic [25:0] miss_addr, snoop_addr, request_addr;
    logic [1:0] miss_waiter_idx, snoop_entry, snoop_state, fill_entry, request_entry;
    logic [3:0] wake_oh;
    logic [2:0] occupancy;
    int n_pass = 0, n_tot = 0;
    bit m_v [4];
    logic [25:0] m_a [4];
    int m_st [4];
    bit [3:0] m_w [4], m_sw [4];
    bit m_up [4];
    int m_ptr, m_occ, m_se, m_ss;
    bit [3:0] m_wake;
    bit m_sh;

    l1_miss_tracker dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .miss_store(miss_store), .miss_waiter_idx(miss_waiter_idx),
        .snoop_en(snoop_en), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
        .snoop_entry(snoop_entry), .snoop_state(snoop_state), .fill_en(fill_en),
        .fill_entry(fill_entry), .wake_oh(wake_oh), .request_valid(request_valid),
        .request_addr(request_addr), .request_store(request_store),
        .request_entry(request_entry), .request_ack(request_ack), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic int m_hit();
        for (int i = 0; i < 4; i++)
            if (m_v[i] && m_a[i] == miss_addr && !(fill_en && fill_entry == 2'(i))) return i;
        return -1;
    endfunction
    function automatic int m_free();
        for (int i = 0; i < 4; i++) if (!m_v[i]) return i;
        return -1;
    endfunction
    function automatic int m_grant();
        for (int k = 0; k < 4; k++)
            if (m_v[(m_ptr + k) % 4] && (m_st[(m_ptr + k) % 4] == 0 || m_st[(m_ptr + k) % 4] == 2)) return (m_ptr + k) % 4;
        return -1;
    endfunction

    // Applies one clock edge of the table's rules to the model using the inputs currently driven.
    task automatic model_step();
        int h, f, g, e;
        bit ack, acc;
        bit [3:0] oh;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_up[i] = 0; m_w[i] = 0; m_sw[i] = 0; end
            m_ptr = 0; m_wake = 0; m_occ = 0; m_sh = 0; m_se = 0; m_ss = 0;
            return;
        end
        h = m_hit(); f = m_free(); g = m_grant();
        ack = request_ack && g >= 0;
        acc = miss_valid && (h >= 0 || f >= 0);
        oh = 4'b0001 << miss_waiter_idx;
        m_sh = 0; m_se = 0; m_ss = 0;
        if (snoop_en) for (int i = 0; i < 4; i++) if (m_v[i] && m_a[i] == snoop_addr) begin m_sh = 1; m_se = i; m_ss = m_st[i]; end
        m_wake = 0;
        if (fill_en) begin
            e = fill_entry;
            m_wake = m_up[e] ? m_w[e] & ~m_sw[e] : m_w[e];
            if (m_up[e]) begin m_st[e] = 2; m_w[e] = m_sw[e]; m_up[e] = 0; end else m_v[e] = 0;
        end
        if (acc && h >= 0) begin
            m_w[h] |= oh;
            if (miss_store) begin
                m_sw[h] |= oh;
                if ((ack && g == h) || m_st[h] == 1) m_up[h] = 1;
                else if (m_st[h] == 0) m_st[h] = 2;
            end
        end
        if (ack) begin m_st[g] += 1; m_ptr = (g + 1) % 4; end
        if (acc && h < 0) begin
            m_v[f] = 1; m_a[f] = miss_addr; m_st[f] = miss_store ? 2 : 0;
            m_w[f] = oh; m_sw[f] = miss_store ? oh : 0; m_up[f] = 0;
        end
        m_occ = 0;
        for (int i = 0; i < 4; i++) m_occ += int'(m_v[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic idle();
        miss_valid = 0; miss_addr = 0; miss_store = 0; miss_waiter_idx = 0;
        snoop_en = 0; snoop_addr = 0; fill_en = 0; fill_entry = 0; request_ack = 0;
    endtask
    task automatic miss(input logic [25:0] a, input bit st, input logic [1:0] t);
        miss_valid = 1; miss_addr = a; miss_store = st; miss_waiter_idx = t;
        tick();
        idle();
    endtask
    task automatic do_reset();
        idle(); reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tot++; if (occupancy !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
        n_tot++; if (request_valid !== 1'b0) $display("FAIL reset_req got %0b want 0", request_valid); else n_pass++;
        n_tot++; if (wake_oh !== 4'b0) $display("FAIL reset_wake got %b want 0000", wake_oh); else n_pass++;
        n_tot++; if (snoop_hit !== 1'b0) $display("FAIL reset_snoop got %0b want 0", snoop_hit); else n_pass++;
        n_tot++; if (miss_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", miss_ready); else n_pass++;
    endtask

    task automatic test_load_miss();
        miss(26'h100, 0, 2'd2);
        #1;
        n_tot++; if (request_valid !== 1'b1 || request_addr !== 26'h100 || request_store !== 1'b0 || request_entry !== 2'd0)
            $display("FAIL load_req got v=%0b a=%h s=%0b e=%0d want v=1 a=100 s=0 e=0", request_valid, request_addr, request_store, request_entry); else n_pass++;
        request_ack = 1; tick(); idle();
        snoop_en = 1; snoop_addr = 26'h100; tick(); idle();
        n_tot++; if (snoop_hit !== 1'b1 || snoop_state !== 2'd1 || snoop_entry !== 2'd0)
            $display("FAIL load_snoop got h=%0b st=%0d e=%0d want h=1 st=1 e=0", snoop_hit, snoop_state, snoop_entry); else n_pass++;
        fill_en = 1; fill_entry = 0; tick(); idle();
        n_tot++; if (wake_oh !== 4'b0100 || occupancy !== 3'd0) $display("FAIL load_fill got wake=%b occ=%0d want 0100 0", wake_oh, occupancy); else n_pass++;
        tick();
        n_tot++; if (wake_oh !== 4'b0) $display("FAIL load_wake_clear got %b want 0000", wake_oh); else n_pass++;
    endtask

    task automatic test_merge_loads();
        miss(26'h200, 0, 2'd0);
        miss_valid = 1; miss_addr = 26'h200; miss_waiter_idx = 2'd3; #1;
        n_tot++; if (miss_ready !== 1'b1) $display("FAIL merge_ready got %0b want 1", miss_ready); else n_pass++;
        tick(); idle(); #1;
        n_tot++; if (occupancy !== 3'd1 || request_valid !== 1'b1 || request_addr !== 26'h200)
            $display("FAIL merge_one_entry got occ=%0d v=%0b a=%h want 1 1 200", occupancy, request_valid, request_addr); else n_pass++;
        request_ack = 1; tick(); idle(); #1;
        n_tot++; if (request_valid !== 1'b0) $display("FAIL merge_single_req got %0b want 0", request_valid); else n_pass++;
        fill_en = 1; fill_entry = 0; tick(); idle();
        n_tot++; if (wake_oh !== 4'b1001) $display("FAIL merge_wake got %b want 1001", wake_oh); else n_pass++;
    endtask

    task automatic test_promote();
        miss(26'h300, 0, 2'd1);
        miss(26'h300, 1, 2'd2);
        #1;
        n_tot++; if (request_store !== 1'b1) $display("FAIL promote_store got %0b want 1", request_store); else n_pass++;
        snoop_en = 1; snoop_addr = 26'h300; tick(); idle();
        n_tot++; if (snoop_state !== 2'd2 || snoop_hit !== 1'b1) $display("FAIL promote_snoop got h=%0b st=%0d want 1 2", snoop_hit, snoop_state); else n_pass++;
        request_ack = 1; tick(); idle();
        fill_en = 1; fill_entry = 0; tick(); idle();
        n_tot++; if (wake_oh !== 4'b0110 || occupancy !== 3'd0) $display("FAIL promote_fill got wake=%b occ=%0d want 0110 0", wake_oh, occupancy); else n_pass++;
    endtask

    task automatic test_upgrade();
        miss(26'h400, 0, 2'd0);
        request_ack = 1; tick(); idle();
        miss(26'h400, 1, 2'd1);
        snoop_en = 1; snoop_addr = 26'h400; tick(); idle();
        n_tot++; if (snoop_state !== 2'd1) $display("FAIL upgrade_snoop got %0d want 1", snoop_state); else n_pass++;
        fill_en = 1; fill_entry = 0; tick(); idle();
        n_tot++; if (wake_oh !== 4'b0001 || occupancy !== 3'd1) $display("FAIL upgrade_fill1 got wake=%b occ=%0d want 0001 1", wake_oh, occupancy); else n_pass++;
        n_tot++; if (request_valid !== 1'b1 || request_store !== 1'b1 || request_addr !== 26'h400)
            $display("FAIL upgrade_rearm got v=%0b s=%0b a=%h want 1 1 400", request_valid, request_store, request_addr); else n_pass++;
        request_ack = 1; tick(); idle();
        fill_en = 1; fill_entry = 0; tick(); idle();
        n_tot++; if (wake_oh !== 4'b0010 || occupancy !== 3'd0) $display("FAIL upgrade_fill2 got wake=%b occ=%0d want 0010 0", wake_oh, occupancy); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int t = 0; t < 4; t++) miss(26'h500 + 26'(t * 16), 0, 2'(t));
        miss_addr = 26'h540; #1;
        n_tot++; if (miss_ready !== 1'b0 || occupancy !== 3'd4) $display("FAIL full_ready got rdy=%0b occ=%0d want 0 4", miss_ready, occupancy); else n_pass++;
        miss_addr = 26'h510; #1;
        n_tot++; if (miss_ready !== 1'b1) $display("FAIL full_merge_ready got %0b want 1", miss_ready); else n_pass++;
        idle();
        request_ack = 1; for (int k = 0; k < 4; k++) tick(); idle();
        fill_en = 1; fill_entry = 0; miss_addr = 26'h540; #1;
        n_tot++; if (miss_ready !== 1'b0) $display("FAIL full_fill_not_free got %0b want 0", miss_ready); else n_pass++;
        tick(); idle();
        n_tot++; if (wake_oh !== 4'b0001 || occupancy !== 3'd3) $display("FAIL full_fill got wake=%b occ=%0d want 0001 3", wake_oh, occupancy); else n_pass++;
        miss_valid = 1; miss_addr = 26'h540; miss_waiter_idx = 0; #1;
        n_tot++; if (miss_ready !== 1'b1) $display("FAIL full_fifth_ready got %0b want 1", miss_ready); else n_pass++;
        tick(); idle();
        n_tot++; if (occupancy !== 3'd4 || request_entry !== 2'd0 || request_addr !== 26'h540)
            $display("FAIL full_fifth got occ=%0d e=%0d a=%h want 4 0 540", occupancy, request_entry, request_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        miss(26'h600, 0, 2'd0);
        miss_valid = 1; miss_addr = 26'h610; miss_waiter_idx = 2'd1; request_ack = 1; tick(); idle();
        request_ack = 1; tick(); idle();
        fill_en = 1; fill_entry = 0; tick(); idle();
        miss(26'h620, 0, 2'd2);
        miss(26'h630, 0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tot++; if (request_entry !== 2'd2 || request_addr !== 26'h630) $display("FAIL rr_hold%0d got e=%0d a=%h want 2 630", k, request_entry, request_addr); else n_pass++;
        end
        request_ack = 1; tick(); idle();
        n_tot++; if (request_entry !== 2'd0 || request_addr !== 26'h620) $display("FAIL rr_next got e=%0d a=%h want 0 620", request_entry, request_addr); else n_pass++;
        request_ack = 1; miss_valid = 1; miss_addr = 26'h620; miss_store = 1; miss_waiter_idx = 2'd3; tick(); idle();
        n_tot++; if (request_valid !== 1'b0) $display("FAIL rr_drained got %0b want 0", request_valid); else n_pass++;
        fill_en = 1; fill_entry = 0; tick(); idle();
        n_tot++; if (wake_oh !== 4'b0100 || occupancy !== 3'd3 || request_entry !== 2'd0 || request_store !== 1'b1)
            $display("FAIL ack_merge_upgrade got wake=%b occ=%0d e=%0d s=%0b want 0100 3 0 1", wake_oh, occupancy, request_entry, request_store); else n_pass++;
        reset = 1; fill_en = 1; fill_entry = 2; tick(); reset = 0; idle();
        n_tot++; if (occupancy !== 3'd0 || request_valid !== 1'b0 || wake_oh !== 4'b0)
            $display("FAIL midreset got occ=%0d v=%0b wake=%b want 0 0 0000", occupancy, request_valid, wake_oh); else n_pass++;
        tick();
        n_tot++; if (wake_oh !== 4'b0) $display("FAIL midreset_wake got %b want 0000", wake_oh); else n_pass++;
    endtask

    task automatic test_random();
        logic [25:0] pool [6] = '{26'h10, 26'h20, 26'h30, 26'h40, 26'h50, 26'h60};
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit [3:0] busy;
            int t, g, sent [$];
            idle();
            busy = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_v[i]) busy |= m_w[i];
                if (m_v[i] && (m_st[i] == 1 || m_st[i] == 3)) sent.push_back(i);
            end
            if (sent.size() > 0 && $urandom % 3 == 0) begin fill_en = 1; fill_entry = 2'(sent[$urandom % sent.size()]); end
            request_ack = 1'($urandom % 2);
            snoop_en = 1'($urandom % 2); snoop_addr = pool[$urandom % 6];
            t = $urandom % 4;
            for (int k = 0; k < 4 && busy[t]; k++) t = (t + 1) % 4;
            if (!busy[t] && $urandom % 4 != 0) begin
                miss_valid = 1; miss_addr = pool[$urandom % 6]; miss_store = ($urandom % 10) < 3; miss_waiter_idx = 2'(t);
                if (fill_en && m_up[fill_entry] && m_a[fill_entry] == miss_addr) miss_valid = 0;
            end
            reset = ($urandom % 200) == 0;
            #1;
            g = m_grant();
            n_tot++; if (miss_ready !== (m_hit() >= 0 || m_free() >= 0)) $display("FAIL rnd_ready c=%0d got %0b", c, miss_ready); else n_pass++;
            n_tot++; if (request_valid !== (g >= 0)) $display("FAIL rnd_req_valid c=%0d got %0b want %0b", c, request_valid, g >= 0); else n_pass++;
            if (g >= 0) begin
                n_tot++; if (request_entry !== 2'(g) || request_addr !== m_a[g] || request_store !== (m_st[g] == 2))
                    $display("FAIL rnd_grant c=%0d got e=%0d a=%h s=%0b want e=%0d a=%h s=%0b", c, request_entry, request_addr, request_store, g, m_a[g], m_st[g] == 2); else n_pass++;
            end
            tick();
            reset = 0;
            n_tot++; if (wake_oh !== m_wake) $display("FAIL rnd_wake c=%0d got %b want %b", c, wake_oh, m_wake); else n_pass++;
            n_tot++; if (occupancy !== 3'(m_occ)) $display("FAIL rnd_occ c=%0d got %0d want %0d", c, occupancy, m_occ); else n_pass++;
            n_tot++; if (snoop_hit !== m_sh) $display("FAIL rnd_snoop_hit c=%0d got %0b want %0b", c, snoop_hit, m_sh); else n_pass++;
            if (m_sh) begin
                n_tot++; if (snoop_entry !== 2'(m_se) || snoop_state !== 2'(m_ss))
                    $display("FAIL rnd_snoop c=%0d got e=%0d st=%0d want e=%0d st=%0d", c, snoop_entry, snoop_state, m_se, m_ss); else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_load_miss();
        test_merge_loads();
        test_promote();
        test_upgrade();
        test_full();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
